// File: rtl/ioclk_gate_array.sv
// Purpose: array of CH_NUM glitch-free gated copies of CLKIN with synchronized enables and min on/off hold.
// Latency: DI change -> GATE_ON after SYNC_STAGES+1 posedges; CLKOUT follows at the next negedge.
// Backpressure: none; requests arriving during the hold window wait (BUSY=1) until the hold expires.
module ioclk_gate_array #(
  parameter int    CH_NUM      = 4,
  parameter int    SYNC_STAGES = 2,
  parameter int    HOLD_CYCLES = 4,
  parameter logic  INIT_ON     = 1'b0,
  parameter string GATE_EN     = "TRUE"
) (
  input  logic              CLKIN,
  input  logic              RSTN,
  input  logic [CH_NUM-1:0] DI,
  output logic [CH_NUM-1:0] CLKOUT,
  output logic [CH_NUM-1:0] GATE_ON,
  output logic [CH_NUM-1:0] BUSY
);

  // Hold counter is at least one bit wide, even when HOLD_CYCLES is 0.
  localparam int            CW       = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);
  // Anything other than "TRUE" falls back to bypass.
  localparam bit            GATING   = (GATE_EN == "TRUE");

  localparam logic [0:0] ST_OFF = 1'b0;
  localparam logic [0:0] ST_ON  = 1'b1;

  generate
    if (GATE_EN != "TRUE" && GATE_EN != "FALSE") begin : g_bad_gate_en
      $error("ioclk_gate_array: GATE_EN must be \"TRUE\" or \"FALSE\"; behaving as bypass");
    end
  endgenerate

  genvar g;
  generate
    for (g = 0; g < CH_NUM; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic [0:0]             r_gate;
      logic [CW-1:0]          r_cnt;
      logic                   r_en_n;
      logic                   w_req;

      assign w_req = r_sync[SYNC_STAGES-1];

      // Bring the asynchronous request into the CLKIN domain.
      always_ff @(posedge CLKIN or negedge RSTN) begin
        if (!RSTN) begin
          r_sync <= {SYNC_STAGES{INIT_ON}};
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], DI[g]};
        end
      end

      // Gate FSM: follow the request only once the current state has been held long enough.
      // The counter resets to saturation so the first transition after reset is never blocked.
      always_ff @(posedge CLKIN or negedge RSTN) begin
        if (!RSTN) begin
          r_gate <= INIT_ON;
          r_cnt  <= HOLD_MAX;
        end else if ((w_req != r_gate[0]) && (r_cnt == HOLD_MAX)) begin
          r_gate <= (r_gate == ST_OFF) ? ST_ON : ST_OFF;
          r_cnt  <= '0;
        end else if (r_cnt != HOLD_MAX) begin
          r_cnt  <= r_cnt + CW'(1);
        end
      end

      // Retime the gate state onto the falling edge so CLKOUT can only change while CLKIN is low.
      always_ff @(negedge CLKIN or negedge RSTN) begin
        if (!RSTN) begin
          r_en_n <= INIT_ON;
        end else begin
          r_en_n <= r_gate[0];
        end
      end

      assign CLKOUT[g]  = GATING ? (CLKIN & r_en_n) : CLKIN;
      assign GATE_ON[g] = GATING ? r_gate[0] : 1'b1;
      assign BUSY[g]    = GATING ? (w_req ^ r_gate[0]) : 1'b0;
    end
  endgenerate

endmodule
